fft_pip_seq_ctrl: RTL
=====================

// Module: fft_pip_seq_ctrl
// PURPOSE
//  Frame sequencer and stall controller for the radix-2^RADIX_LOG2, 2^FFT_N_LOG2-point FFT datapath pipeline.
//  Admits one frame of N samples via a valid/ready handshake and drives one global enable to every datapath
//  pipeline register. Tracks per-stage valid, SOF and EOF tags alongside the data.
//  Generates the sample index and first-stage twiddle exponent for the on-the-fly twiddle unit.
// PARAMETERS
//  P_WIDTH     64  datapath word width; sets no logic here, passed through for consistency
//  FFT_N_LOG2  14  log2 of frame length N (N = 16384)
//  RADIX_LOG2   4  log2 of radix R (R = 16)
//  PIP_DEPTH    4  number of datapath register stages controlled by pip_en (>=1)
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           reset, synchronous, active-low
//  start      in   1           request a new frame; sampled only in IDLE
//  in_valid   in   1           upstream sample valid
//  in_ready   out  1           controller accepts a sample this cycle
//  out_ready  in   1           downstream can take the pipeline output
//  out_valid  out  1           pipeline output valid (= vld[PIP_DEPTH-1])
//  pip_en     out  1           global enable for all datapath pipeline registers
//  sample_idx out  FFT_N_LOG2  index of the sample accepted in the previous cycle
//  tw_exp     out  FFT_N_LOG2  twiddle exponent for sample_idx
//  tw_valid   out  1           sample_idx and tw_exp are valid (= vld[0])
//  out_sof    out  1           output word is sample 0 of the frame
//  out_eof    out  1           output word is sample N-1 of the frame
//  busy       out  1           state != IDLE
//  done       out  1           1-cycle pulse when the frame has fully drained
// BEHAVIOUR
//  Reset: at a rising clk edge with rst_n=0, state=IDLE and all counters, vld/sof/eof shift registers,
//   sample_idx, tw_exp and done are cleared to 0. All outputs then read 0, except pip_en=1 (out_valid=0).
//   Reset mid-frame discards everything in flight; no done pulse is produced.
//  pip_en = ~out_valid | out_ready (combinational). The pipeline stalls only when the output word is held.
//  in_ready = (state==RUN) & pip_en. accept = in_valid & in_ready. in_ready never depends on in_valid.
//  Shift registers vld, sof and eof have PIP_DEPTH bits each and shift only when pip_en=1.
//   On a shift: vld[0]<=accept, sof[0]<=accept&(in_cnt==0), eof[0]<=accept&(in_cnt==N-1).
//   On a stall, all bits hold. out_valid/out_sof/out_eof are taken from bit PIP_DEPTH-1.
//   Latency from accept to out_valid is PIP_DEPTH cycles when there are no stalls.
//  in_cnt (FFT_N_LOG2 bits) is 0 on entering RUN and increments on each accept.
//  On each accept, register sample_idx<=in_cnt and tw_exp<=in_cnt[FFT_N_LOG2-RADIX_LOG2-1:0]*in_cnt[FFT_N_LOG2-1:FFT_N_LOG2-RADIX_LOG2].
//   The product is truncated to FFT_N_LOG2 bits. It is < N for all legal params, so no wrap occurs.
//   Both registers hold their value when there is no accept.
//  FSM:
//   IDLE : start=1 -> RUN, clear in_cnt. start during RUN/DRAIN is ignored, not queued.
//   RUN  : accept with in_cnt==N-1 -> DRAIN. in_ready=0 from then on.
//   DRAIN: out_valid&out_ready&out_eof -> IDLE, with done=1 for exactly one cycle (the cycle after that handshake).
//  start and the final handshake in the same cycle: the FSM goes to IDLE. start is not captured and must be
//   re-asserted once state is IDLE.
//  An out_valid&~out_ready stall freezes every stage. Output sof/eof/valid stay stable until the handshake.
//  Bubbles (in_valid=0 in RUN) propagate as vld=0 holes. Frame order is preserved and out_valid is never
//   asserted for a bubble.
// TESTING (bench params FFT_N_LOG2=6, RADIX_LOG2=2, PIP_DEPTH=3; N=64, N/R=16)
//  1. Reset then start, in_valid=1, out_ready=1 held -> first out_valid 3 cycles after the first accept;
//     64 consecutive valid outputs; out_sof on output 0, out_eof on output 63; done pulses 1 cycle later.
//  2. Twiddle check on accepting idx 17 / 63 / 40 -> next cycle tw_valid=1, tw_exp = 1 / 45 / 16.
//  3. out_ready=0 for 5 cycles mid-frame -> pip_en=0 and in_ready=0; out_valid and the data index hold;
//     no sample lost or duplicated.
//  4. in_valid toggled 1,0,1,0 in RUN -> outputs contain matching bubbles; in_cnt advances only on accepts.
//  5. start pulsed during DRAIN -> ignored, busy stays 1; after done, state IDLE with in_ready=0 until a new start.
//  6. rst_n=0 for 1 cycle at accept #30 -> next cycle all outputs 0 except pip_en=1, no done; a new frame
//     then starts cleanly from idx 0.

Source files
------------

// File: rtl/fft_pip_seq_ctrl.sv
// Frame sequencer and stall controller for the FFT datapath pipeline.
// Admits one N-sample frame, drives the global pipeline enable, tags each
// stage with valid/SOF/EOF, and feeds the twiddle unit its index and exponent.
module fft_pip_seq_ctrl #(
    parameter int unsigned P_WIDTH    = 64,
    parameter int unsigned FFT_N_LOG2 = 14,
    parameter int unsigned RADIX_LOG2 = 4,
    parameter int unsigned PIP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  pip_en,
    output logic [FFT_N_LOG2-1:0] sample_idx,
    output logic [FFT_N_LOG2-1:0] tw_exp,
    output logic                  tw_valid,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  busy,
    output logic                  done
);

    // Width of the low (within-group) part of the sample index.
    localparam int unsigned LO_W = FFT_N_LOG2 - RADIX_LOG2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [FFT_N_LOG2-1:0] in_cnt;
    logic [PIP_DEPTH-1:0]  vld;
    logic [PIP_DEPTH-1:0]  sof;
    logic [PIP_DEPTH-1:0]  eof;
    logic [PIP_DEPTH-1:0]  vld_sh;
    logic [PIP_DEPTH-1:0]  sof_sh;
    logic [PIP_DEPTH-1:0]  eof_sh;
    logic                  accept;
    logic                  cnt_last;
    logic                  cnt_first;
    logic                  frame_end;
    logic [FFT_N_LOG2-1:0] tw_prod;

    // Datapath width is carried only for interface consistency.
    logic unused_p_width;
    assign unused_p_width = (P_WIDTH != 0);

    // Handshake and enable decode; the pipeline stalls only on a held output.
    assign out_valid = vld[PIP_DEPTH-1];
    assign out_sof   = sof[PIP_DEPTH-1];
    assign out_eof   = eof[PIP_DEPTH-1];
    assign tw_valid  = vld[0];
    assign pip_en    = ~out_valid | out_ready;
    assign in_ready  = (state == S_RUN) & pip_en;
    assign accept    = in_valid & in_ready;
    assign busy      = (state != S_IDLE);
    assign cnt_last  = &in_cnt;
    assign cnt_first = (in_cnt == '0);
    assign frame_end = (state == S_DRAIN) & out_valid & out_ready & out_eof;

    // Shift-in values; the cast drops the bit that falls off the last stage.
    assign vld_sh = PIP_DEPTH'({vld, accept});
    assign sof_sh = PIP_DEPTH'({sof, accept & cnt_first});
    assign eof_sh = PIP_DEPTH'({eof, accept & cnt_last});

    // First-stage twiddle exponent: low index part times high radix digit.
    assign tw_prod = FFT_N_LOG2'(in_cnt[LO_W-1:0]) * FFT_N_LOG2'(in_cnt[FFT_N_LOG2-1:LO_W]);

    // Next-state logic: start is honoured only in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)              state_nxt = S_RUN;
            S_RUN:   if (accept && cnt_last) state_nxt = S_DRAIN;
            S_DRAIN: if (frame_end)          state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Input sample counter, cleared on frame start and advanced per accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            in_cnt <= '0;
        end else if (accept) begin
            in_cnt <= in_cnt + FFT_N_LOG2'(1);
        end
    end

    // Per-stage valid/SOF/EOF tags, moving in lockstep with the datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            sof <= '0;
            eof <= '0;
        end else if (pip_en) begin
            vld <= vld_sh;
            sof <= sof_sh;
            eof <= eof_sh;
        end
    end

    // Sample index and twiddle exponent of the most recently accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_idx <= '0;
            tw_exp     <= '0;
        end else if (accept) begin
            sample_idx <= in_cnt;
            tw_exp     <= tw_prod;
        end
    end

    // One-cycle completion pulse after the final output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) done <= 1'b0;
        else        done <= frame_end;
    end

endmodule
